// File: rtl/seq_shift_add_mult.sv
// Iterative shift-and-add multiplier, one multiplier bit per clock, signed or unsigned.
// Define SEQ_MULT_EARLY_TERM_EN to end RUN once the remaining multiplier bits are all zero.
module seq_shift_add_mult #(
  parameter int WIDTH = 32
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 start,
  input  logic                 is_signed,
  input  logic [WIDTH-1:0]     a,
  input  logic [WIDTH-1:0]     b,
  output logic                 busy,
  output logic                 done,
  output logic [2*WIDTH-1:0]   product
);

  localparam int PW = 2 * WIDTH;
  localparam int CW = $clog2(WIDTH);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t            state_q, state_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              neg_q, neg_d;
  logic [PW-1:0]     acc_q, acc_d;
  logic [PW-1:0]     mcand_q, mcand_d;
  logic [PW-1:0]     product_q, product_d;
  logic [WIDTH-1:0]  mult_q, mult_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic              last_bit;

  // Magnitude fits in WIDTH unsigned bits, including the most-negative value.
  function automatic logic [WIDTH-1:0] magnitude(input logic [WIDTH-1:0] v, input logic sgn);
    return (sgn && v[WIDTH-1]) ? -v : v;
  endfunction

`ifdef SEQ_MULT_EARLY_TERM_EN
  assign last_bit = (cnt_q == CW'(WIDTH - 1)) || ((mult_q >> 1) == '0);
`else
  assign last_bit = (cnt_q == CW'(WIDTH - 1));
`endif

  always_comb begin
    state_d   = state_q;
    busy_d    = busy_q;
    done_d    = done_q;
    neg_d     = neg_q;
    acc_d     = acc_q;
    mcand_d   = mcand_q;
    mult_d    = mult_q;
    cnt_d     = cnt_q;
    product_d = product_q;
    case (state_q)
      IDLE: begin
        done_d = 1'b0;
        busy_d = start;
        if (start) begin
          mcand_d = PW'(magnitude(a, is_signed));
          mult_d  = magnitude(b, is_signed);
          neg_d   = is_signed & (a[WIDTH-1] ^ b[WIDTH-1]);
          acc_d   = '0;
          cnt_d   = '0;
          state_d = RUN;
        end
      end
      RUN: begin
        if (mult_q[0]) acc_d = acc_q + mcand_q;
        mcand_d = mcand_q << 1;
        mult_d  = mult_q >> 1;
        cnt_d   = cnt_q + CW'(1);
        if (last_bit) state_d = DONE;
      end
      DONE: begin
        // Result registers load here; busy stays up through the done pulse cycle.
        product_d = neg_q ? -acc_q : acc_q;
        done_d    = 1'b1;
        state_d   = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= IDLE;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      neg_q     <= 1'b0;
      acc_q     <= '0;
      mcand_q   <= '0;
      mult_q    <= '0;
      cnt_q     <= '0;
      product_q <= '0;
    end else begin
      state_q   <= state_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      neg_q     <= neg_d;
      acc_q     <= acc_d;
      mcand_q   <= mcand_d;
      mult_q    <= mult_d;
      cnt_q     <= cnt_d;
      product_q <= product_d;
    end
  end

  assign busy    = busy_q;
  assign done    = done_q;
  assign product = product_q;

endmodule

// File: tb/tb_seq_shift_add_mult.sv
// Directed-vector bench for seq_shift_add_mult at WIDTH=32.
module tb_seq_shift_add_mult;
  localparam int W = 32;

  logic           clk = 1'b0;
  logic           reset, start, is_signed;
  logic [W-1:0]   a, b;
  logic           busy, done;
  logic [2*W-1:0] product;

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic [W-1:0]   a;
    logic [W-1:0]   b;
    logic           sgn;
    logic [2*W-1:0] p;
  } vec_t;

  vec_t vecs[12];

  seq_shift_add_mult #(.WIDTH(W)) dut (
    .clk(clk), .reset(reset), .start(start), .is_signed(is_signed),
    .a(a), .b(b), .busy(busy), .done(done), .product(product)
  );

  always #5 clk = ~clk;

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Cycles from the start edge to the first cycle with done high.
  function automatic int exp_lat(input logic [W-1:0] bv, input logic sgn);
    logic [W-1:0] m;
    int hi;
    m  = (sgn && bv[W-1]) ? -bv : bv;
    hi = 0;
    for (int i = 0; i < W; i++) if (m[i]) hi = i;
`ifdef SEQ_MULT_EARLY_TERM_EN
    return 2 + hi;
`else
    return (hi >= 0) ? W + 1 : 0;
`endif
  endfunction

  task automatic run_op(input logic [W-1:0] av, input logic [W-1:0] bv, input logic sgn,
                        input logic [63:0] expp, input string nm);
    int   n;
    logic busy_ok;
    n = 0;
    busy_ok = 1'b1;
    @(negedge clk);
    a = av; b = bv; is_signed = sgn; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0; a = $urandom; b = $urandom; is_signed = ~sgn;
    while (1) begin
      @(posedge clk); #1;
      n++;
      if (!busy) busy_ok = 1'b0;
      if (done || n >= 100) break;
    end
    check({nm, " latency"}, 64'(n), 64'(exp_lat(bv, sgn)));
    check({nm, " product"}, product, expp);
    check({nm, " busy"}, 64'(busy_ok), 64'd1);
    @(posedge clk); #1;
    check({nm, " idle"}, {62'd0, busy, done}, 64'd0);
    check({nm, " held"}, product, expp);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    int n, dcount, dlat, inj;
    logic [63:0] dprod;

    vecs[0]  = '{32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0, 64'hFFFFFFFE00000001};
    vecs[1]  = '{32'hFFFFFFFD, 32'h00000007, 1'b1, 64'hFFFFFFFFFFFFFFEB};
    vecs[2]  = '{32'hFFFFFFFD, 32'h00000007, 1'b0, 64'h00000006FFFFFFEB};
    vecs[3]  = '{32'h80000000, 32'h80000000, 1'b1, 64'h4000000000000000};
    vecs[4]  = '{32'h80000000, 32'h00000001, 1'b1, 64'hFFFFFFFF80000000};
    vecs[5]  = '{32'h00001234, 32'h00000001, 1'b0, 64'h0000000000001234};
    vecs[6]  = '{32'h00000000, 32'hFFFFFFFF, 1'b1, 64'h0000000000000000};
    vecs[7]  = '{32'h00000001, 32'h80000000, 1'b0, 64'h0000000080000000};
    vecs[8]  = '{32'hFFFFFFFF, 32'hFFFFFFFF, 1'b1, 64'h0000000000000001};
    vecs[9]  = '{32'h00010000, 32'h00010000, 1'b0, 64'h0000000100000000};
    vecs[10] = '{32'h00000007, 32'hFFFFFFFB, 1'b1, 64'hFFFFFFFFFFFFFFDD};
    vecs[11] = '{32'h00000005, 32'h00000000, 1'b1, 64'h0000000000000000};

    reset = 1'b1; start = 1'b0; is_signed = 1'b0; a = '0; b = '0;
    repeat (3) @(posedge clk);
    #1;
    check("reset busy", 64'(busy), 64'd0);
    check("reset done", 64'(done), 64'd0);
    check("reset product", product, 64'd0);
    reset = 1'b0;

    for (int i = 0; i < 12; i++) run_op(vecs[i].a, vecs[i].b, vecs[i].sgn, vecs[i].p, $sformatf("vec%0d", i));

    // A start during RUN must be ignored.
`ifdef SEQ_MULT_EARLY_TERM_EN
    inj = 1;
`else
    inj = 10;
`endif
    @(negedge clk);
    a = 32'd5; b = 32'd6; is_signed = 1'b0; start = 1'b1;
    @(posedge clk); #1;
    start = (inj == 1); a = 32'd9; b = 32'd9;
    n = 0; dcount = 0; dlat = 0; dprod = '0;
    while (n < 60) begin
      @(posedge clk); #1;
      n++;
      if (done) begin
        dcount++;
        if (dcount == 1) begin dlat = n; dprod = product; end
      end
      start = (n == inj - 1);
    end
    check("busy-start done count", 64'(dcount), 64'd1);
    check("busy-start latency", 64'(dlat), 64'(exp_lat(32'd6, 1'b0)));
    check("busy-start product", dprod, 64'd30);
    check("busy-start held", product, 64'd30);

    // Reset in the middle of an operation.
    @(negedge clk);
    a = 32'h00001234; b = 32'h80000001; is_signed = 1'b0; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (14) @(posedge clk);
    #1;
    check("mid busy before reset", 64'(busy), 64'd1);
    reset = 1'b1;
    @(posedge clk); #1;
    check("mid reset busy", 64'(busy), 64'd0);
    check("mid reset done", 64'(done), 64'd0);
    check("mid reset product", product, 64'd0);
    reset = 1'b0;
    run_op(32'd2, 32'd3, 1'b0, 64'd6, "after reset");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
